// File: rtl/axis_byte_packer.sv
// axis_byte_packer: packs a byte-wide AXI-Stream into big-endian words of
// WORD_WIDTH bits. One word assembles while the previous completed word waits
// downstream. An optional idle timeout discards a stale partial word so that
// word alignment recovers after a glitch or an aborted transfer.
module axis_byte_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [WORD_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  drop
);

  localparam int NUM_BYTES = WORD_WIDTH / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  // With a single-byte word there is no accumulator; keep a dummy byte so
  // the declarations stay legal. It is never loaded in that configuration.
  localparam int ACC_W     = (NUM_BYTES > 1) ? (NUM_BYTES - 1) * 8 : 8;
  localparam int IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                TO_EN     = (TIMEOUT > 0);

  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [ACC_W-1:0]      acc, acc_next;
  logic [IDLE_W-1:0]     idle, idle_next;
  logic [WORD_WIDTH-1:0] data_next;
  logic                  valid_next;
  logic                  drop_next;

  logic                  accept;
  logic                  last_byte;
  logic                  idle_tick;
  logic                  fire;
  logic [ACC_W+7:0]      shifted;

  // The last byte is refused while a finished word still waits; this keeps
  // m_axis_tready out of the input-side ready path.
  assign last_byte     = (cnt == LAST_CNT);
  assign s_axis_tready = !arst && !(last_byte && m_axis_tvalid);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign shifted       = {acc, s_axis_tdata};
  assign idle_tick     = TO_EN && (cnt != '0) && s_axis_tready && !accept;
  assign fire          = idle_tick && (idle == IDLE_LAST);

  // Next-state logic: byte accumulation, word hand-off and idle timeout.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned and infer a latch.
    cnt_next   = cnt;
    acc_next   = acc;
    idle_next  = idle;
    data_next  = m_axis_tdata;
    valid_next = m_axis_tvalid;
    drop_next  = 1'b0;

    if (m_axis_tvalid && m_axis_tready) begin
      valid_next = 1'b0;
    end

    if (accept) begin
      // An accepted byte always beats a timeout firing in the same cycle.
      idle_next = '0;
      if (last_byte) begin
        cnt_next   = '0;
        data_next  = shifted[WORD_WIDTH-1:0];
        valid_next = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
        acc_next = shifted[ACC_W-1:0];
      end
    end else if (fire) begin
      cnt_next  = '0;
      idle_next = '0;
      drop_next = 1'b1;
    end else if (idle_tick) begin
      idle_next = idle + 1'b1;
    end else if (cnt == '0) begin
      idle_next = '0;
    end
  end

  // State register; reset clears everything, including the accumulator.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt           <= '0;
      acc           <= '0;
      idle          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      drop          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the same pre-edge state.
      cnt           <= cnt_next;
      acc           <= acc_next;
      idle          <= idle_next;
      m_axis_tdata  <= data_next;
      m_axis_tvalid <= valid_next;
      drop          <= drop_next;
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Testbench for axis_byte_packer: a 32-bit instance with a 16-cycle timeout
// driven from a per-cycle vector table, plus hand-written reset and
// single-byte-word sequences.
module tb_axis_byte_packer;

  logic        clk = 1'b0;
  logic        arst = 1'b0;

  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        drop;

  logic [7:0]  s8_data = '0;
  logic        s8_valid = 1'b0;
  logic        s8_ready;
  logic [7:0]  m8_data;
  logic        m8_valid;
  logic        m8_ready = 1'b0;
  logic        drop8;

  int checks = 0;
  int errors = 0;

  axis_byte_packer #(.WORD_WIDTH(32), .TIMEOUT(16)) dut (
    .clk           (clk),
    .arst          (arst),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .drop          (drop)
  );

  axis_byte_packer #(.WORD_WIDTH(8), .TIMEOUT(0)) dut8 (
    .clk           (clk),
    .arst          (arst),
    .s_axis_tdata  (s8_data),
    .s_axis_tvalid (s8_valid),
    .s_axis_tready (s8_ready),
    .m_axis_tdata  (m8_data),
    .m_axis_tvalid (m8_valid),
    .m_axis_tready (m8_ready),
    .drop          (drop8)
  );

  always #5 clk = ~clk;

  // One vector = inputs for one cycle and the outputs expected in that cycle.
  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        m_ready;
    logic        exp_s_ready;
    logic        exp_m_valid;
    logic [31:0] exp_m_data;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] data, input logic valid, input logic mr,
                     input logic er, input logic emv, input logic [31:0] ed,
                     input logic edrop);
    vec_t v;
    v.data = data; v.valid = valid; v.m_ready = mr;
    v.exp_s_ready = er; v.exp_m_valid = emv; v.exp_m_data = ed; v.exp_drop = edrop;
    vecs.push_back(v);
  endtask

  // Drive one cycle on the 32-bit instance and compare its state-derived outputs.
  task automatic step(input string tag, input logic [7:0] data, input logic valid,
                      input logic mr, input logic er, input logic emv,
                      input logic [31:0] ed, input logic edrop);
    @(negedge clk);
    s_data  = data;
    s_valid = valid;
    m_ready = mr;
    #1;
    check({tag, " s_ready"}, {31'd0, s_ready}, {31'd0, er});
    check({tag, " m_valid"}, {31'd0, m_valid}, {31'd0, emv});
    check({tag, " m_data"},  m_data, ed);
    check({tag, " drop"},    {31'd0, drop}, {31'd0, edrop});
  endtask

  initial begin
    logic [7:0] next_byte;
    logic       mv_model;
    logic [7:0] md_model;

    // ---- build the vector table ----
    // Basic packing, downstream always ready.
    add(8'h12, 1, 1, 1, 0, 32'h0, 0);
    add(8'h34, 1, 1, 1, 0, 32'h0, 0);
    add(8'h56, 1, 1, 1, 0, 32'h0, 0);
    add(8'h78, 1, 1, 1, 0, 32'h0, 0);
    add(8'h00, 0, 1, 1, 1, 32'h12345678, 0);
    add(8'h00, 0, 1, 1, 0, 32'h12345678, 0);
    // Backpressure: 0x01..0x08 with downstream stalled.
    add(8'h01, 1, 0, 1, 0, 32'h12345678, 0);
    add(8'h02, 1, 0, 1, 0, 32'h12345678, 0);
    add(8'h03, 1, 0, 1, 0, 32'h12345678, 0);
    add(8'h04, 1, 0, 1, 0, 32'h12345678, 0);
    add(8'h05, 1, 0, 1, 1, 32'h01020304, 0);
    add(8'h06, 1, 0, 1, 1, 32'h01020304, 0);
    add(8'h07, 1, 0, 1, 1, 32'h01020304, 0);
    add(8'h08, 1, 0, 0, 1, 32'h01020304, 0);
    add(8'h08, 1, 0, 0, 1, 32'h01020304, 0);
    add(8'h08, 1, 1, 0, 1, 32'h01020304, 0);
    add(8'h08, 1, 1, 1, 0, 32'h01020304, 0);
    add(8'h00, 0, 1, 1, 1, 32'h05060708, 0);
    add(8'h00, 0, 1, 1, 0, 32'h05060708, 0);
    // Timeout resync: 0xAA 0xBB, 16 idle cycles, drop, then a clean word.
    add(8'hAA, 1, 1, 1, 0, 32'h05060708, 0);
    add(8'hBB, 1, 1, 1, 0, 32'h05060708, 0);
    for (int i = 0; i < 16; i++) add(8'h00, 0, 1, 1, 0, 32'h05060708, 0);
    add(8'h01, 1, 1, 1, 0, 32'h05060708, 1);
    add(8'h02, 1, 1, 1, 0, 32'h05060708, 0);
    add(8'h03, 1, 1, 1, 0, 32'h05060708, 0);
    add(8'h04, 1, 1, 1, 0, 32'h05060708, 0);
    add(8'h00, 0, 1, 1, 1, 32'h01020304, 0);
    add(8'h00, 0, 1, 1, 0, 32'h01020304, 0);
    // Timeout race: the next byte arrives on the cycle the timeout would fire.
    add(8'hAA, 1, 1, 1, 0, 32'h01020304, 0);
    for (int i = 0; i < 15; i++) add(8'h00, 0, 1, 1, 0, 32'h01020304, 0);
    add(8'hBB, 1, 1, 1, 0, 32'h01020304, 0);
    add(8'hCC, 1, 1, 1, 0, 32'h01020304, 0);
    add(8'hDD, 1, 1, 1, 0, 32'h01020304, 0);
    add(8'h00, 0, 1, 1, 1, 32'hAABBCCDD, 0);
    add(8'h00, 0, 1, 1, 0, 32'hAABBCCDD, 0);

    // ---- initial reset ----
    #2 arst = 1'b1;
    #1;
    check("reset s_ready",  {31'd0, s_ready}, 32'd0);
    check("reset m_valid",  {31'd0, m_valid}, 32'd0);
    check("reset m_data",   m_data, 32'd0);
    check("reset drop",     {31'd0, drop}, 32'd0);
    check("reset s8_ready", {31'd0, s8_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;

    // ---- table-driven run ----
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].data, vecs[i].valid, vecs[i].m_ready,
           vecs[i].exp_s_ready, vecs[i].exp_m_valid, vecs[i].exp_m_data,
           vecs[i].exp_drop);
    end

    // ---- reset mid-operation: pending word plus two bytes assembling ----
    step("rst_a1", 8'hA1, 1, 0, 1, 0, 32'hAABBCCDD, 0);
    step("rst_a2", 8'hA2, 1, 0, 1, 0, 32'hAABBCCDD, 0);
    step("rst_a3", 8'hA3, 1, 0, 1, 0, 32'hAABBCCDD, 0);
    step("rst_a4", 8'hA4, 1, 0, 1, 0, 32'hAABBCCDD, 0);
    step("rst_b1", 8'hB1, 1, 0, 1, 1, 32'hA1A2A3A4, 0);
    step("rst_b2", 8'hB2, 1, 0, 1, 1, 32'hA1A2A3A4, 0);
    @(negedge clk);
    s_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    check("midrst s_ready", {31'd0, s_ready}, 32'd0);
    check("midrst m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst m_data",  m_data, 32'd0);
    check("midrst drop",    {31'd0, drop}, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    step("post_11", 8'h11, 1, 1, 1, 0, 32'h0, 0);
    step("post_12", 8'h12, 1, 1, 1, 0, 32'h0, 0);
    step("post_13", 8'h13, 1, 1, 1, 0, 32'h0, 0);
    step("post_14", 8'h14, 1, 1, 1, 0, 32'h0, 0);
    step("post_w",  8'h00, 0, 1, 1, 1, 32'h11121314, 0);
    step("post_w2", 8'h00, 0, 1, 1, 0, 32'h11121314, 0);

    // ---- width 8: continuous valid bytes, one accepted every 2 cycles ----
    next_byte = 8'h40;
    mv_model  = 1'b0;
    md_model  = 8'h00;
    m8_ready  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      s8_data  = next_byte;
      s8_valid = 1'b1;
      #1;
      check($sformatf("w8 c%0d s_ready", c), {31'd0, s8_ready}, {31'd0, !mv_model});
      check($sformatf("w8 c%0d m_valid", c), {31'd0, m8_valid}, {31'd0, mv_model});
      check($sformatf("w8 c%0d m_data", c),  {24'd0, m8_data}, {24'd0, md_model});
      check($sformatf("w8 c%0d drop", c),    {31'd0, drop8}, 32'd0);
      if (!mv_model) begin
        md_model  = next_byte;
        mv_model  = 1'b1;
        next_byte = next_byte + 8'h13;
      end else begin
        mv_model = 1'b0;
      end
    end
    @(negedge clk);
    s8_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
